// File: rtl/uart_tx_packetizer_if.sv
// ---------------------------------------------------------------------------
// uart_tx_packetizer_if
//
// Purpose: bundles every non-clock signal of uart_tx_packetizer. One side is
// the system (payload producer plus the uart_tx busy flag). The other side is
// the packetizer itself.
//
// Signals:
//   data_strobe        producer -> packetizer  one-cycle write of data
//   data[7:0]          producer -> packetizer  payload byte
//   packet_send        producer -> packetizer  one-cycle packet request
//   uart_tx_active     uart_tx  -> packetizer  transmitter busy flag
//   uart_tx_send_byte  packetizer -> uart_tx   one-cycle byte pulse
//   uart_tx_byte[7:0]  packetizer -> uart_tx   byte, valid with pulse
//   busy               packetizer -> producer  packet in progress
//   fifo_full          packetizer -> producer  FIFO holds DEPTH bytes
//   overflow           packetizer -> producer  sticky dropped-write flag
//
// Modports:
//   master  system side; drives the inputs and observes the outputs.
//   slave   packetizer side.
// ---------------------------------------------------------------------------
interface uart_tx_packetizer_if;
    logic       data_strobe;
    logic [7:0] data;
    logic       packet_send;
    logic       uart_tx_active;
    logic       uart_tx_send_byte;
    logic [7:0] uart_tx_byte;
    logic       busy;
    logic       fifo_full;
    logic       overflow;

    modport master (
        output data_strobe,
        output data,
        output packet_send,
        output uart_tx_active,
        input  uart_tx_send_byte,
        input  uart_tx_byte,
        input  busy,
        input  fifo_full,
        input  overflow
    );

    modport slave (
        input  data_strobe,
        input  data,
        input  packet_send,
        input  uart_tx_active,
        output uart_tx_send_byte,
        output uart_tx_byte,
        output busy,
        output fifo_full,
        output overflow
    );
endinterface

// File: rtl/uart_tx_packetizer.sv
// ---------------------------------------------------------------------------
// uart_tx_packetizer
//
// Purpose: buffers payload bytes in a circular FIFO. On request, it sends the
// FIFO contents to uart_tx as one packet:
//   SYNC_BYTE, LEN_LO, LEN_HI, LEN payload bytes, CSUM
// CSUM is the XOR of LEN_LO, LEN_HI and all payload bytes.
//
// Parameters:
//   DEPTH      FIFO depth in bytes. Must be a power of two, 4..32768.
//   SYNC_BYTE  first byte of every packet.
//
// Ports:
//   clock      system clock
//   reset_n    asynchronous active-low reset
//   bus        uart_tx_packetizer_if.slave; carries the producer inputs, the
//              uart_tx handshake and the status outputs.
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module uart_tx_packetizer #(
    parameter int         DEPTH     = 256,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    uart_tx_packetizer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM
    } state_t;

    // Handshake sub-phase used in every non-IDLE state.
    // PH_ISSUE: the byte for this state is still owed. It is issued in the
    //   first cycle that uart_tx_active is low, and the pulse is registered
    //   for the following cycle.
    // PH_WAIT_HI: the pulse cycle and after; waits for uart_tx_active to go high.
    // PH_WAIT_LO: waits for uart_tx_active to go low, then advances.
    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_WAIT_HI,
        PH_WAIT_LO
    } phase_t;

    state_t          state_q, state_d;
    phase_t          phase_q, phase_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     len_q, len_d;
    logic [15:0]     left_q, left_d;
    logic [7:0]      csum_q, csum_d;
    logic            send_q, send_d;
    logic [7:0]      byte_q, byte_d;
    logic            busy_q, busy_d;
    logic            full_q, full_d;
    logic            ovf_q, ovf_d;

    logic            fifo_is_full;
    logic            wr_en;
    logic            pop;
    logic            ovf_clr;

    // Payload storage. There is no reset: emptiness is tracked by the
    // pointers and the count. The read is captured in byte_q.
    logic [7:0]      fifo_mem [DEPTH];

    assign fifo_is_full = (count_q == CW'(DEPTH));
    assign wr_en        = bus.data_strobe && !fifo_is_full;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            fifo_mem[wr_ptr_q] <= bus.data;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        len_d    = len_q;
        left_d   = left_q;
        csum_d   = csum_q;
        send_d   = 1'b0;
        byte_d   = byte_q;
        busy_d   = busy_q;
        pop      = 1'b0;
        ovf_clr  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.packet_send) begin
                    // LEN uses the count before any same-cycle write, so a
                    // byte written in this cycle belongs to the next packet.
                    len_d   = 16'(count_q);
                    left_d  = 16'(count_q);
                    busy_d  = 1'b1;
                    ovf_clr = 1'b1;
                    state_d = ST_SYNC;
                    phase_d = PH_ISSUE;
                end
            end
            default: begin
                case (phase_q)
                    PH_WAIT_HI: begin
                        if (bus.uart_tx_active) begin
                            phase_d = PH_WAIT_LO;
                        end
                    end
                    PH_WAIT_LO: begin
                        if (!bus.uart_tx_active) begin
                            phase_d = PH_ISSUE;
                            case (state_q)
                                ST_SYNC:   state_d = ST_LEN_LO;
                                ST_LEN_LO: state_d = ST_LEN_HI;
                                ST_LEN_HI: state_d = (len_q == 16'd0) ? ST_CSUM : ST_DATA;
                                ST_DATA:   state_d = (left_q == 16'd0) ? ST_CSUM : ST_DATA;
                                default: begin
                                    state_d = ST_IDLE;
                                    busy_d  = 1'b0;
                                end
                            endcase
                        end
                    end
                    default: ;
                endcase
            end
        endcase

        // Issue the owed byte as soon as the transmitter is idle. This also
        // applies in the cycle a state is entered. As a result, the next pulse
        // follows the observed falling edge of uart_tx_active by one cycle.
        if ((state_d != ST_IDLE) && (phase_d == PH_ISSUE) && !bus.uart_tx_active) begin
            send_d  = 1'b1;
            phase_d = PH_WAIT_HI;
            case (state_d)
                ST_SYNC: begin
                    byte_d = SYNC_BYTE;
                    csum_d = 8'h00;
                end
                ST_LEN_LO: begin
                    byte_d = len_q[7:0];
                    csum_d = csum_q ^ len_q[7:0];
                end
                ST_LEN_HI: begin
                    byte_d = len_q[15:8];
                    csum_d = csum_q ^ len_q[15:8];
                end
                ST_DATA: begin
                    byte_d = fifo_mem[rd_ptr_q];
                    csum_d = csum_q ^ fifo_mem[rd_ptr_q];
                    pop    = 1'b1;
                    left_d = left_q - 16'd1;
                end
                default: begin
                    byte_d = csum_q;
                end
            endcase
        end
    end

    // FIFO bookkeeping. Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_en ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop   ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d = (count_d == CW'(DEPTH));
        // A write dropped in the accept cycle is a new event, so setting the
        // flag takes priority over clearing it.
        ovf_d  = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (bus.data_strobe && fifo_is_full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            phase_q  <= PH_ISSUE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            len_q    <= '0;
            left_q   <= '0;
            csum_q   <= '0;
            send_q   <= 1'b0;
            byte_q   <= '0;
            busy_q   <= 1'b0;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            len_q    <= len_d;
            left_q   <= left_d;
            csum_q   <= csum_d;
            send_q   <= send_d;
            byte_q   <= byte_d;
            busy_q   <= busy_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.uart_tx_send_byte = send_q;
    assign bus.uart_tx_byte      = byte_q;
    assign bus.busy              = busy_q;
    assign bus.fifo_full         = full_q;
    assign bus.overflow          = ovf_q;
endmodule

// File: tb/tb_uart_tx_packetizer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_packetizer
//
// Two packetizers run on one clock: a DEPTH=256 instance and a DEPTH=4
// instance. Each has its own uart_tx model. The model raises active one
// cycle after a pulse and holds it for three cycles. Stimulus pushes the
// expected bytes into a per-instance queue. A monitor at the falling edge
// pops and compares each pulsed byte. It also flags any pulse seen while
// uart_tx_active is high.
// ---------------------------------------------------------------------------
module tb_uart_tx_packetizer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_packetizer_if if256 ();
    uart_tx_packetizer_if if4 ();

    uart_tx_packetizer #(.DEPTH(256), .SYNC_BYTE(8'hA5)) dut256 (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (if256)
    );

    uart_tx_packetizer #(.DEPTH(4), .SYNC_BYTE(8'hA5)) dut4 (
        .clock   (clk),
        .reset_n (rst_n),
        .bus     (if4)
    );

    int total = 0;
    int bad   = 0;
    int pulses256 = 0;
    int pulses4   = 0;
    logic [7:0] exp256 [$];
    logic [7:0] exp4   [$];

    // uart_tx models. They are not reset: an in-flight byte finishes on its own.
    logic       hold256 = 1'b0;
    logic       pend256 = 1'b0;
    logic [2:0] cnt256  = 3'd0;
    logic       pend4   = 1'b0;
    logic [2:0] cnt4    = 3'd0;

    assign if256.uart_tx_active = (cnt256 != 3'd0) || hold256;
    assign if4.uart_tx_active   = (cnt4 != 3'd0);

    always @(posedge clk) begin
        pend256 <= if256.uart_tx_send_byte;
        if (pend256)              cnt256 <= 3'd3;
        else if (cnt256 != 3'd0)  cnt256 <= cnt256 - 3'd1;
        pend4 <= if4.uart_tx_send_byte;
        if (pend4)                cnt4 <= 3'd3;
        else if (cnt4 != 3'd0)    cnt4 <= cnt4 - 3'd1;
    end

    // Scoreboard monitors.
    always @(negedge clk) begin
        if (if256.uart_tx_send_byte) begin
            logic [7:0] e;
            pulses256++;
            total++;
            if (if256.uart_tx_active) begin
                bad++;
                $display("FAIL pulse_while_active256: active=%b required 0", if256.uart_tx_active);
            end
            total++;
            if (exp256.size() == 0) begin
                bad++;
                $display("FAIL byte256: got unexpected pulse %h, required no pulse", if256.uart_tx_byte);
            end else begin
                e = exp256.pop_front();
                if (if256.uart_tx_byte !== e) begin
                    bad++;
                    $display("FAIL byte256: got %h required %h", if256.uart_tx_byte, e);
                end else begin
                    $display("byte256 %h ok", if256.uart_tx_byte);
                end
            end
        end
        if (if4.uart_tx_send_byte) begin
            logic [7:0] e;
            pulses4++;
            total++;
            if (if4.uart_tx_active) begin
                bad++;
                $display("FAIL pulse_while_active4: active=%b required 0", if4.uart_tx_active);
            end
            total++;
            if (exp4.size() == 0) begin
                bad++;
                $display("FAIL byte4: got unexpected pulse %h, required no pulse", if4.uart_tx_byte);
            end else begin
                e = exp4.pop_front();
                if (if4.uart_tx_byte !== e) begin
                    bad++;
                    $display("FAIL byte4: got %h required %h", if4.uart_tx_byte, e);
                end else begin
                    $display("byte4 %h ok", if4.uart_tx_byte);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end else begin
            $display("check %s = %h ok", name, act);
        end
    endtask

    task automatic write256(input logic [7:0] b);
        if256.data_strobe = 1'b1;
        if256.data        = b;
        tick();
        if256.data_strobe = 1'b0;
    endtask

    task automatic write4(input logic [7:0] b);
        if4.data_strobe = 1'b1;
        if4.data        = b;
        tick();
        if4.data_strobe = 1'b0;
    endtask

    task automatic send256();
        if256.packet_send = 1'b1;
        tick();
        if256.packet_send = 1'b0;
    endtask

    task automatic push256(input logic [7:0] b);
        exp256.push_back(b);
    endtask

    task automatic push4(input logic [7:0] b);
        exp4.push_back(b);
    endtask

    task automatic drain256();
        int n;
        n = 0;
        while ((if256.busy || exp256.size() != 0) && n < 2000) begin
            tick();
            n++;
        end
        check("drain256_timeout", {15'd0, (n >= 2000)}, 16'd0);
        check("busy256_after", {15'd0, if256.busy}, 16'd0);
    endtask

    task automatic drain4();
        int n;
        n = 0;
        while ((if4.busy || exp4.size() != 0) && n < 2000) begin
            tick();
            n++;
        end
        check("drain4_timeout", {15'd0, (n >= 2000)}, 16'd0);
        check("busy4_after", {15'd0, if4.busy}, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary line");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int n;
        rst_n = 1'b0;
        if256.data_strobe = 1'b0; if256.data = 8'h00; if256.packet_send = 1'b0;
        if4.data_strobe   = 1'b0; if4.data   = 8'h00; if4.packet_send   = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_send",  {15'd0, if256.uart_tx_send_byte}, 16'd0);
        check("rst_byte",  {8'd0, if256.uart_tx_byte}, 16'd0);
        check("rst_busy",  {15'd0, if256.busy}, 16'd0);
        check("rst_full",  {15'd0, if256.fifo_full}, 16'd0);
        check("rst_ovf",   {15'd0, if256.overflow}, 16'd0);
        check("rst_full4", {15'd0, if4.fifo_full}, 16'd0);
        rst_n = 1'b1;
        tick();

        // Three-byte packet; CSUM = 03^00^11^22^33 = 03
        write256(8'h11); write256(8'h22); write256(8'h33);
        push256(8'hA5); push256(8'h03); push256(8'h00);
        push256(8'h11); push256(8'h22); push256(8'h33); push256(8'h03);
        send256();
        check("accept_busy", {15'd0, if256.busy}, 16'd1);
        check("accept_pulse", {15'd0, if256.uart_tx_send_byte}, 16'd1);
        check("accept_byte", {8'd0, if256.uart_tx_byte}, 16'h00A5);
        drain256();

        // Empty FIFO: header and checksum only
        push256(8'hA5); push256(8'h00); push256(8'h00); push256(8'h00);
        send256();
        drain256();

        // DEPTH=4 fill and overflow; CSUM = 04^00^01^02^03^04 = 00
        write4(8'h01); write4(8'h02); write4(8'h03);
        check("full4_after3", {15'd0, if4.fifo_full}, 16'd0);
        write4(8'h04);
        check("full4_after4", {15'd0, if4.fifo_full}, 16'd1);
        check("ovf4_after4",  {15'd0, if4.overflow}, 16'd0);
        write4(8'h05);
        check("ovf4_after5",  {15'd0, if4.overflow}, 16'd1);
        push4(8'hA5); push4(8'h04); push4(8'h00);
        push4(8'h01); push4(8'h02); push4(8'h03); push4(8'h04); push4(8'h00);
        if4.packet_send = 1'b1;
        tick();
        if4.packet_send = 1'b0;
        check("ovf4_cleared", {15'd0, if4.overflow}, 16'd0);
        drain4();
        check("full4_drained", {15'd0, if4.fifo_full}, 16'd0);

        // Write in the accept cycle goes to the next packet; a mid-packet
        // request is ignored. First CSUM = 02^44^55 = 13.
        write256(8'h44); write256(8'h55);
        push256(8'hA5); push256(8'h02); push256(8'h00);
        push256(8'h44); push256(8'h55); push256(8'h13);
        if256.data_strobe = 1'b1; if256.data = 8'hAA; if256.packet_send = 1'b1;
        tick();
        if256.data_strobe = 1'b0; if256.packet_send = 1'b0;
        repeat (9) tick();
        send256();
        repeat (10) tick();
        write256(8'hBB);
        repeat (3) tick();
        write256(8'hCC);
        drain256();
        // Second packet CSUM = 03^AA^BB^CC = DE
        push256(8'hA5); push256(8'h03); push256(8'h00);
        push256(8'hAA); push256(8'hBB); push256(8'hCC); push256(8'hDE);
        send256();
        drain256();

        // Transmitter busy at request: no pulse until it drops. CSUM = 01^5A = 5B
        hold256 = 1'b1;
        write256(8'h5A);
        push256(8'hA5); push256(8'h01); push256(8'h00); push256(8'h5A); push256(8'h5B);
        p0 = pulses256;
        send256();
        repeat (10) tick();
        check("hold_no_pulse", 16'(pulses256 - p0), 16'd0);
        check("hold_busy", {15'd0, if256.busy}, 16'd1);
        hold256 = 1'b0;
        drain256();

        // Reset during DATA
        write256(8'h01); write256(8'h02); write256(8'h03);
        push256(8'hA5); push256(8'h03); push256(8'h00); push256(8'h01);
        send256();
        n = 0;
        while (exp256.size() != 0 && n < 1000) begin
            tick();
            n++;
        end
        check("reach_data_timeout", {15'd0, (n >= 1000)}, 16'd0);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_send", {15'd0, if256.uart_tx_send_byte}, 16'd0);
        check("midrst_byte", {8'd0, if256.uart_tx_byte}, 16'd0);
        check("midrst_busy", {15'd0, if256.busy}, 16'd0);
        check("midrst_ovf",  {15'd0, if256.overflow}, 16'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (8) tick();
        check("post_rst_busy", {15'd0, if256.busy}, 16'd0);
        push256(8'hA5); push256(8'h00); push256(8'h00); push256(8'h00);
        send256();
        drain256();

        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
